// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// CPU side: 32-bit load/store port with one-cycle completion pulse.
// Memory side: initiator of whole-block reads (fill) and writes (evict) on
// the MInput/MOutput block bus defined in mem_pkg below.
// Optional hit/miss statistics counters: define DM_CACHE_STATS_EN.

package mem_pkg;
  localparam int unsigned BLOCK_SIZE = 128;

  typedef struct packed {
    logic                  Valid;
    logic                  Wen;
    logic [31:0]           Addr;
    logic [BLOCK_SIZE-1:0] WriteD;
  } MInput;

  typedef struct packed {
    logic [BLOCK_SIZE-1:0] ReadD;
    logic                  Ready;
  } MOutput;
endpackage

module dm_cache_ctrl #(
  parameter int unsigned BLOCK_SIZE     = 128,
  parameter int unsigned BLOCK_ADDR_BIT = 4,
  parameter int unsigned NUM_SETS       = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CpuValid_i,
  input  logic              CpuWen_i,
  input  logic [31:0]       CpuAddr_i,
  input  logic [31:0]       CpuWriteD_i,
  input  logic [3:0]        CpuByteEn_i,
  output logic [31:0]       CpuReadD_o,
  output logic              CpuReady_o,
  output mem_pkg::MInput    MemReq_o,
  input  mem_pkg::MOutput   MemResp_i,
  output logic [31:0]       HitCount_o,
  output logic [31:0]       MissCount_o
);

  localparam int unsigned IDX_W  = $clog2(NUM_SETS);
  localparam int unsigned TAG_W  = 32 - BLOCK_ADDR_BIT - IDX_W;
  localparam int unsigned WSEL_W = BLOCK_ADDR_BIT - 2;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    GAP,
    ALLOCATE
  } state_t;

  state_t                state_q, state_d;

  logic                  req_wen_q;
  logic [31:2]           req_addr_q;
  logic [31:0]           req_wd_q;
  logic [3:0]            req_be_q;
  logic                  refill_q, refill_d;
  logic                  latch_req;

  logic [NUM_SETS-1:0]   valid_q;
  logic [NUM_SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]      tag_arr  [NUM_SETS];
  logic [BLOCK_SIZE-1:0] data_arr [NUM_SETS];

  mem_pkg::MInput        mem_req_q, mem_req_d;
  logic                  cpu_ready_q, cpu_ready_d;
  logic [31:0]           cpu_rd_q, cpu_rd_d;

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic [WSEL_W-1:0]     wsel;
  logic [WSEL_W+4:0]     word_lsb;
  logic [TAG_W-1:0]      cur_tag;
  logic [BLOCK_SIZE-1:0] line;
  logic [31:0]           word;
  logic [31:0]           merged_word;
  logic [BLOCK_SIZE-1:0] merged_line;
  logic                  hit;

  logic                  do_fill;
  logic                  do_store;
  logic                  hit_inc;
  logic                  miss_inc;
  logic                  unused_addr_lsb;

  // Address decode and hit/merge datapath for the latched request
  always_comb begin
    unused_addr_lsb = ^CpuAddr_i[1:0];
    idx      = req_addr_q[BLOCK_ADDR_BIT +: IDX_W];
    tag      = req_addr_q[31 -: TAG_W];
    wsel     = req_addr_q[BLOCK_ADDR_BIT-1:2];
    word_lsb = {wsel, 5'd0};
    cur_tag  = tag_arr[idx];
    line     = data_arr[idx];
    hit      = valid_q[idx] && (cur_tag == tag);
    word     = line[word_lsb +: 32];
    merged_word = word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (req_be_q[b]) merged_word[8*b +: 8] = req_wd_q[8*b +: 8];
    end
    merged_line = line;
    merged_line[word_lsb +: 32] = merged_word;
  end

  // Next-state and next registered-output logic
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    cpu_ready_d = 1'b0;
    cpu_rd_d    = cpu_rd_q;
    refill_d    = refill_q;
    latch_req   = 1'b0;
    do_fill     = 1'b0;
    do_store    = 1'b0;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;
    case (state_q)
      IDLE: begin
        if (CpuValid_i && !cpu_ready_q) begin
          latch_req = 1'b1;
          refill_d  = 1'b0;
          state_d   = COMPARE;
        end
      end
      COMPARE: begin
        if (hit) begin
          if (req_wen_q) do_store = 1'b1;
          else           cpu_rd_d = word;
          cpu_ready_d = 1'b1;
          hit_inc     = !refill_q;
          state_d     = IDLE;
        end else begin
          miss_inc = !refill_q;
          if (valid_q[idx] && dirty_q[idx]) begin
            mem_req_d.Valid  = 1'b1;
            mem_req_d.Wen    = 1'b1;
            mem_req_d.Addr   = {cur_tag, idx, {BLOCK_ADDR_BIT{1'b0}}};
            mem_req_d.WriteD = line;
            state_d          = WRITEBACK;
          end else begin
            mem_req_d.Valid  = 1'b1;
            mem_req_d.Wen    = 1'b0;
            mem_req_d.Addr   = {tag, idx, {BLOCK_ADDR_BIT{1'b0}}};
            mem_req_d.WriteD = '0;
            state_d          = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        if (MemResp_i.Ready) begin
          mem_req_d.Valid = 1'b0;
          state_d         = GAP;
        end
      end
      GAP: begin
        mem_req_d.Valid  = 1'b1;
        mem_req_d.Wen    = 1'b0;
        mem_req_d.Addr   = {tag, idx, {BLOCK_ADDR_BIT{1'b0}}};
        mem_req_d.WriteD = '0;
        state_d          = ALLOCATE;
      end
      ALLOCATE: begin
        if (MemResp_i.Ready) begin
          do_fill         = 1'b1;
          mem_req_d.Valid = 1'b0;
          refill_d        = 1'b1;
          state_d         = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, line status bits and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= '0;
      cpu_ready_q <= 1'b0;
      cpu_rd_q    <= '0;
      refill_q    <= 1'b0;
      valid_q     <= '0;
      dirty_q     <= '0;
      req_wen_q   <= 1'b0;
      req_addr_q  <= '0;
      req_wd_q    <= '0;
      req_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rd_q    <= cpu_rd_d;
      refill_q    <= refill_d;
      if (latch_req) begin
        req_wen_q  <= CpuWen_i;
        req_addr_q <= CpuAddr_i[31:2];
        req_wd_q   <= CpuWriteD_i;
        req_be_q   <= CpuByteEn_i;
      end
      if (do_fill) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (do_store) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays (not reset; guarded by valid bits)
  always_ff @(posedge clk) begin
    if (do_fill) begin
      data_arr[idx] <= MemResp_i.ReadD;
      tag_arr[idx]  <= tag;
    end else if (do_store) begin
      data_arr[idx] <= merged_line;
    end
  end

  assign MemReq_o   = mem_req_q;
  assign CpuReady_o = cpu_ready_q;
  assign CpuReadD_o = cpu_rd_q;

`ifdef DM_CACHE_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Saturating first-pass hit and miss counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_inc && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_inc && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign HitCount_o  = hit_cnt_q;
  assign MissCount_o = miss_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = hit_inc | miss_inc;
  assign HitCount_o   = '0;
  assign MissCount_o  = '0;
`endif

endmodule
